// File: rtl/polar_link_pkg.sv
// Shared types and default widths for the polar link frame scheduler.
package polar_link_pkg;

    localparam int unsigned DEF_DATA_W     = 128;
    localparam int unsigned DEF_CODE_W     = 256;
    localparam int unsigned DEF_CODE_BYTES = DEF_CODE_W / 8;
    localparam int unsigned DEF_BYTE_CNT_W = $clog2(DEF_CODE_BYTES) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StEncWait,
        StTx,
        StChk
    } state_e;

endpackage

// File: rtl/polar_link_ctrl_fifo.sv
// frame_fifo2: two-entry frame FIFO; a push while full is accepted only
// when a pop happens in the same cycle.
module frame_fifo2 #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/polar_link_ctrl.sv
// Frame scheduler: queues frames, launches the encoder, serialises codewords MSB byte first.
// Optional trailing XOR checksum byte enabled by defining POLAR_LINK_CHKSUM_EN.
module polar_link_ctrl
    import polar_link_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned CODE_W = DEF_CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] frm_data,
    input  logic              frm_vld,
    output logic [DATA_W-1:0] enc_data,
    output logic              enc_start,
    input  logic [CODE_W-1:0] enc_code,
    input  logic              enc_done,
    output logic [7:0]        tx_data,
    output logic              tx_vld,
    input  logic              tx_rdy,
    output logic              busy,
    output logic              frm_drop
);

    localparam int unsigned NBytes = CODE_W / 8;
    localparam int unsigned CntW   = $clog2(NBytes) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NBytes - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] enc_data_q, enc_data_d;
    logic              enc_start_q, enc_start_d;
    logic [CODE_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic              tx_vld_q, tx_vld_d;
    logic              busy_q, busy_d;
    logic              drop_q, drop_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              push_ok;
    logic              fifo_empty_nxt;
    logic              xfer;

`ifdef POLAR_LINK_CHKSUM_EN
    logic [7:0] chk_q, chk_d;

    function automatic logic [7:0] xor_bytes(input logic [CODE_W-1:0] v);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < int'(NBytes); i++) begin
            acc ^= v[i*8 +: 8];
        end
        return acc;
    endfunction
`endif

    frame_fifo2 #(
        .WIDTH(DATA_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (frm_vld),
        .pop  (fifo_pop),
        .din  (frm_data),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        enc_data_d = enc_data_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        fifo_pop   = 1'b0;
        xfer       = tx_vld_q && tx_rdy;
`ifdef POLAR_LINK_CHKSUM_EN
        chk_d      = chk_q;
`endif

        unique case (state_q)
            // A frame pushed this cycle is already in the FIFO by the LOAD cycle.
            StIdle: begin
                if (!fifo_empty || frm_vld) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                fifo_pop   = 1'b1;
                enc_data_d = fifo_dout;
                state_d    = StStart;
            end
            StStart: begin
                state_d = StEncWait;
            end
            StEncWait: begin
                if (enc_done) begin
                    shift_d    = enc_code;
                    byte_cnt_d = '0;
`ifdef POLAR_LINK_CHKSUM_EN
                    chk_d      = xor_bytes(enc_code);
`endif
                    state_d    = StTx;
                end
            end
            StTx: begin
                if (xfer) begin
                    shift_d    = shift_q << 8;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == LastCnt) begin
`ifdef POLAR_LINK_CHKSUM_EN
                        shift_d = {chk_q, {(CODE_W-8){1'b0}}};
                        state_d = StChk;
`else
                        state_d = StIdle;
`endif
                    end
                end
            end
`ifdef POLAR_LINK_CHKSUM_EN
            StChk: begin
                if (xfer) begin
                    state_d = StIdle;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase

        push_ok        = frm_vld && (!fifo_full || fifo_pop);
        fifo_empty_nxt = fifo_empty ? !push_ok : (!fifo_full && fifo_pop && !push_ok);

        enc_start_d = (state_q == StLoad);
        tx_vld_d    = (state_d == StTx) || (state_d == StChk);
        busy_d      = (state_d != StIdle) || !fifo_empty_nxt;
        drop_d      = frm_vld && fifo_full && !fifo_pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            enc_data_q  <= '0;
            enc_start_q <= 1'b0;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            tx_vld_q    <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            enc_data_q  <= enc_data_d;
            enc_start_q <= enc_start_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_vld_q    <= tx_vld_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

`ifdef POLAR_LINK_CHKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    assign enc_data  = enc_data_q;
    assign enc_start = enc_start_q;
    assign tx_data   = shift_q[CODE_W-1 -: 8];
    assign tx_vld    = tx_vld_q;
    assign busy      = busy_q;
    assign frm_drop  = drop_q;

endmodule

// File: doc/polar_link_ctrl.md
# polar_link_ctrl

Frame scheduler between the UART frame receiver, the polar encoder core and the UART byte transmitter. It buffers incoming 128-bit message frames in a 2-deep queue and launches the encoder once per frame. It then serialises each returned codeword into bytes for the transmitter, holding one frame in flight at a time. Frames that arrive while the queue is full are dropped and reported.

## Interface
- DATA_W, 128: message frame width; equals receiver frame width.
- CODE_W, 256: encoder codeword width; multiple of 8, ≥16.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- frm_data  in  DATA_W  received frame; valid only when frm_vld=1.
- frm_vld  in  1  single-cycle pulse, one frame per pulse.
- enc_data  out  DATA_W  message to encoder; stable from enc_start until enc_done.
- enc_start  out  1  single-cycle launch pulse.
- enc_code  in  CODE_W  codeword; sampled in the enc_done cycle.
- enc_done  in  1  single-cycle completion pulse.
- tx_data  out  8  byte to transmitter.
- tx_vld  out  1  byte valid; tx_vld and tx_data held until accepted.
- tx_rdy  in  1  transmitter ready; byte transfers when tx_vld && tx_rdy.
- busy  out  1  high whenever the FSM is not in IDLE, or the queue is non-empty.
- frm_drop  out  1  single-cycle pulse: frame lost because the queue was full.

## Operation
- Queue:
  - 2-entry FIFO of DATA_W.
  - frm_vld with queue not full: push.
  - frm_vld with queue full: no push; frm_drop pulses the next cycle.
  - Pop and push in the same cycle while full: the push is accepted, no drop.
- FSM states and transitions:
  - IDLE: go to LOAD if the queue is non-empty.
  - LOAD: pop the head into the enc_data register; go to START.
  - START: enc_start=1 for this cycle only; go to ENC_WAIT.
  - ENC_WAIT: on enc_done, capture enc_code into the shift register, set byte_cnt=0, go to TX.
  - TX: tx_vld=1, tx_data=shift[CODE_W-1 -: 8] (MSB byte first). On transfer, shift left 8 and increment byte_cnt. At byte_cnt=CODE_W/8-1 with transfer, go to IDLE (or CHK when the checksum is enabled).
- An enc_done outside ENC_WAIT is ignored.
- byte_cnt width: $clog2(CODE_W/8)+1; no wrap within a frame.
- Reset mid-operation: state to IDLE and queue emptied; the in-flight frame is discarded, with no drop pulse.

## Timing
- Reset values:
  - enc_data=0, enc_start=0, tx_data=0, tx_vld=0, busy=0, frm_drop=0.
  - Queue empty, state=IDLE.
- Latency on an empty idle block:
  - frm_vld at cycle 0 → push at edge 0.
  - LOAD at cycle 1, enc_start=1 at cycle 2.
- Codeword output:
  - enc_done at cycle N → tx_vld=1 from cycle N+1, first byte = enc_code[CODE_W-1:CODE_W-8].
  - With tx_rdy held high, one byte per cycle; the last byte transfers at N+CODE_W/8.
- Back-to-back frames: the next LOAD occurs the cycle after the return to IDLE.
- All outputs are registered.

## Configuration
- POLAR_LINK_CHKSUM_EN defined:
  - Adds state CHK after the last codeword byte.
  - CHK sends one byte with the same tx handshake: the XOR of all CODE_W/8 codeword bytes, accumulated at capture time.
  - CHK returns to IDLE on transfer.
  - Frame length becomes CODE_W/8+1 bytes.
- Undefined: no CHK state and no accumulator; TX goes directly to IDLE.

## Structure
- Shared package polar_link_pkg holds:
  - FSM state enum (IDLE, LOAD, START, ENC_WAIT, TX, CHK).
  - Default widths DATA_W/CODE_W and the derived byte-count constant.
- The FIFO is a natural sub-module: frame_fifo2, parameterised by width, with push/pop/full/empty outputs.
- The FSM, shift register and checksum stay in polar_link_ctrl.

## Test plan
- Single frame, 128'h0011…EEFF; encoder model returns CODE_W=256 pattern 32'hA5A5_0001 repeated, tx_rdy=1 → enc_start 2 cycles after frm_vld; 32 bytes A5,A5,00,01,… in order; busy falls after the last byte.
- Three frm_vld pulses on consecutive cycles while the encoder stalls 100 cycles → frames 1–2 queued; no drop, since frame 1 is popped at LOAD before frame 3 arrives. Then a 4th pulse during ENC_WAIT with 2 queued → frm_drop one cycle later; exactly 3 codewords transmitted.
- tx_rdy toggled 1,0,0,1 pseudo-randomly → tx_data/tx_vld stable while tx_rdy=0; no byte lost or duplicated.
- Stray enc_done in IDLE → no state change, no tx_vld.
- rst pulsed during TX at byte 5 → outputs to reset values next edge; a fresh frame afterwards is transmitted complete from byte 0.
- POLAR_LINK_CHKSUM_EN, codeword of all 8'h3C bytes (32 bytes) → 33rd byte = 8'h00. Codeword with a single byte 8'h81, rest 0 → last byte 8'h81.
